// File: rtl/pin_group_control.sv
// Pin group controller: a register-mapped bank of NPINS bidirectional pads.
// Each pad can float, drive a constant, or be driven by a 32-bit NCO
// accumulator. All pads are synchronized and can be captured at a
// programmable rate into a sample FIFO that is drained over a valid/ready
// stream.
module pin_group_control #(
    parameter int POSITION   = 0,
    parameter int NPINS      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [18:0]      addr,
    input  logic             data_wr,
    input  logic             data_rd,
    input  logic [15:0]      data_in,
    output logic [15:0]      data_out,
    inout  logic [NPINS-1:0] pin,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [31:0]      sample_data,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_NCO  = 2'd1,
        MODE_LOW  = 2'd2,
        MODE_HIGH = 2'd3
    } pin_mode_t;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_RUN  = 1'b1
    } cap_state_t;

    // Global page register offsets
    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_RATE     = 4'd1;
    localparam logic [3:0] REG_STATUS   = 4'd2;
    localparam logic [3:0] REG_MASK     = 4'd3;
    // Pin page register offsets
    localparam logic [3:0] REG_MODE     = 4'd0;
    localparam logic [3:0] REG_NCO_LOW  = 4'd1;
    localparam logic [3:0] REG_NCO_HIGH = 4'd2;

    // Bus decode
    logic        selected;
    logic [3:0]  page;
    logic [3:0]  reg_sel;
    logic [3:0]  pin_idx;
    logic        page_is_pin;
    logic        wr_global;
    logic        wr_pin;
    logic        cmd_start;
    logic        cmd_stop;
    logic        cmd_flush;
    logic        unused_addr;

    // Per-pin state
    pin_mode_t   mode     [NPINS];
    logic [15:0] nco_low  [NPINS];
    logic [15:0] nco_high [NPINS];
    logic [31:0] acc      [NPINS];

    // Global registers
    logic [15:0]      sample_rate;
    logic [NPINS-1:0] capture_mask;

    // Pad drive and input synchronizer
    logic [NPINS-1:0] pin_oe;
    logic [NPINS-1:0] pin_drive;
    logic [NPINS-1:0] pin_meta;
    logic [NPINS-1:0] pin_sync;

    // Capture engine
    cap_state_t  cap_q;
    cap_state_t  cap_d;
    logic [15:0] rate_cnt;
    logic [15:0] sample_cnt;
    logic        sample_take;
    logic [31:0] sample_word;

    // Sample FIFO
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    fill;
    logic          fifo_full;
    logic          fifo_pop;
    logic          fifo_push;
    logic          fifo_drop;

    // Read path
    logic [15:0] rd_data;

    assign selected    = enable && (addr[15:8] == 8'(POSITION));
    assign page        = addr[7:4];
    assign reg_sel     = addr[3:0];
    assign pin_idx     = page - 4'd1;
    assign page_is_pin = (page != 4'd0) && (page <= 4'(NPINS));
    assign unused_addr = ^addr[18:16];

    assign wr_global = selected && data_wr && (page == 4'd0);
    assign wr_pin    = selected && data_wr && page_is_pin;
    assign cmd_start = wr_global && (reg_sel == REG_CTRL) && (data_in == 16'd1);
    assign cmd_stop  = wr_global && (reg_sel == REG_CTRL) && (data_in == 16'd2);
    assign cmd_flush = wr_global && (reg_sel == REG_CTRL) && (data_in == 16'd3);

    // Global configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_rate  <= '0;
            capture_mask <= '0;
        end else if (wr_global) begin
            if (reg_sel == REG_RATE) begin
                sample_rate <= data_in;
            end
            if (reg_sel == REG_MASK) begin
                capture_mask <= data_in[NPINS-1:0];
            end
        end
    end

    // Per-pin registers and NCO accumulators; accumulator is pinned to zero outside nco mode
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NPINS; i++) begin
            if (reset) begin
                mode[i]     <= MODE_IDLE;
                nco_low[i]  <= '0;
                nco_high[i] <= '0;
                acc[i]      <= '0;
            end else begin
                if (wr_pin && (pin_idx == 4'(i))) begin
                    case (reg_sel)
                        REG_MODE:     mode[i]     <= pin_mode_t'(data_in[1:0]);
                        REG_NCO_LOW:  nco_low[i]  <= data_in;
                        REG_NCO_HIGH: nco_high[i] <= data_in;
                        default:      ;
                    endcase
                end
                if (mode[i] == MODE_NCO) begin
                    acc[i] <= acc[i] + {nco_high[i], nco_low[i]};
                end else begin
                    acc[i] <= '0;
                end
            end
        end
    end

    // Pad output value and enable from the current mode
    always_comb begin
        pin_oe    = '0;
        pin_drive = '0;
        for (int unsigned i = 0; i < NPINS; i++) begin
            pin_oe[i] = (mode[i] != MODE_IDLE);
            case (mode[i])
                MODE_NCO:  pin_drive[i] = acc[i][31];
                MODE_HIGH: pin_drive[i] = 1'b1;
                default:   pin_drive[i] = 1'b0;
            endcase
        end
    end

    for (genvar g = 0; g < NPINS; g++) begin : g_pad
        assign pin[g] = pin_oe[g] ? pin_drive[g] : 1'bz;
    end

    // Two-flop synchronizer on the pad values (driven or not)
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            pin_meta <= pin;
            pin_sync <= pin_meta;
        end
    end

    // Capture state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= CAP_IDLE;
        end else begin
            cap_q <= cap_d;
        end
    end

    // Capture next-state: start (also a restart) and stop commands
    always_comb begin
        cap_d = cap_q;
        if (cmd_start) begin
            cap_d = CAP_RUN;
        end else if (cmd_stop) begin
            cap_d = CAP_IDLE;
        end
    end

    // A capture command in the same cycle takes priority over taking a sample
    assign sample_take = (cap_q == CAP_RUN) && !cmd_start && !cmd_stop &&
                         (rate_cnt <= 16'd1);
    assign sample_word = {sample_cnt, 16'(pin_sync & capture_mask)};

    // Rate counter and sample sequence number
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_cnt   <= '0;
            sample_cnt <= '0;
        end else if (cmd_start) begin
            rate_cnt   <= sample_rate;
            sample_cnt <= '0;
        end else if (sample_take) begin
            rate_cnt   <= sample_rate;
            sample_cnt <= sample_cnt + 16'd1;
        end else if (cap_q == CAP_RUN) begin
            rate_cnt   <= rate_cnt - 16'd1;
        end
    end

    assign sample_valid = (fill != 9'd0);
    assign fifo_full    = (fill == 9'(FIFO_DEPTH));
    assign fifo_pop     = sample_valid && sample_ready;
    assign fifo_push    = sample_take && (!fifo_full || fifo_pop);
    assign fifo_drop    = sample_take && fifo_full && !fifo_pop;
    assign sample_data  = sample_valid ? fifo_mem[rd_ptr] : '0;

    // FIFO storage; contents beyond the pointers are don't-care so no reset
    always_ff @(posedge clk) begin
        if (!reset && !cmd_flush && fifo_push) begin
            fifo_mem[wr_ptr] <= sample_word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; flush discards any push/pop
    always_ff @(posedge clk) begin
        if (reset || cmd_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fill <= fill + 9'd1;
                2'b01:   fill <= fill - 9'd1;
                default: ;
            endcase
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read mux; unmapped offsets and pages read as zero
    always_comb begin
        rd_data = '0;
        if (page == 4'd0) begin
            case (reg_sel)
                REG_RATE:   rd_data = sample_rate;
                REG_STATUS: rd_data = {overflow, (cap_q == CAP_RUN), 5'b0, fill};
                REG_MASK:   rd_data = 16'(capture_mask);
                default:    rd_data = '0;
            endcase
        end else if (page_is_pin) begin
            for (int unsigned i = 0; i < NPINS; i++) begin
                if (pin_idx == 4'(i)) begin
                    case (reg_sel)
                        REG_MODE:     rd_data = {14'd0, mode[i]};
                        REG_NCO_LOW:  rd_data = nco_low[i];
                        REG_NCO_HIGH: rd_data = nco_high[i];
                        default:      rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Registered read data, zero on every cycle without a selected read
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (selected && data_rd) begin
            data_out <= rd_data;
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: doc/pin_group_control.md
PIN_GROUP_CONTROL -- requirements
Module: pin_group_control

Interface
REQ-001 SHALL have parameter POSITION, default 0: block select, matched against addr[15:8].
REQ-002 SHALL have parameter NPINS, default 4: pin count, legal range 1..15.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: sample FIFO entries, power of 2, legal range 4..256.
REQ-004 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports enable (input, 1), addr (input, 19), data_wr (input, 1), data_rd (input, 1): register bus.
REQ-007 SHALL have ports data_in (input, 16) for write data and data_out (output, 16) for registered read data.
REQ-008 SHALL have port pin, inout, NPINS: bidirectional pads.
REQ-009 SHALL have sample_valid (output, 1), sample_ready (input, 1), sample_data (output, 32): sample stream.
REQ-010 SHALL have port overflow, output, 1: sticky sample-drop flag.

Function
REQ-011 SHALL select the block when enable=1 and addr[15:8]==POSITION; addr[7:4]=page (0 global, p=1..NPINS pin p-1); addr[3:0]=register.
REQ-012 SHALL decode global registers: 0 CTRL (W), 1 SAMPLE_RATE (R/W, 16b), 2 STATUS (R), 3 CAPTURE_MASK (R/W, low NPINS bits).
REQ-013 SHALL decode pin registers: 0 MODE (R/W, 2b: 0 idle, 1 nco, 2 low, 3 high), 1 NCO_LOW (R/W), 2 NCO_HIGH (R/W).
REQ-014 SHALL decode CTRL writes: 1 start capture, 2 stop capture, 3 flush FIFO and clear overflow; other values ignored.
REQ-015 SHALL form STATUS as {overflow, capturing, 5'b0, fill[8:0]}, where fill = current FIFO occupancy.
REQ-016 SHALL present read data on data_out the cycle after a selected data_rd; data_out=0 on all other cycles, including unmapped addresses and pages >NPINS.
REQ-017 SHALL keep a 32-bit phase accumulator per pin, adding {NCO_HIGH,NCO_LOW} each cycle in mode nco, wrapping modulo 2^32.
REQ-018 SHALL hold the accumulator at 0 in every mode other than nco; NCO_LOW/NCO_HIGH writes SHALL NOT clear it.
REQ-019 SHALL drive pin[i] per mode: idle Z, nco accumulator bit 31, low 0, high 1; a MODE write takes effect on the following cycle.
REQ-020 SHALL pass each pin through a 2-flop synchronizer before sampling; driven pins are sampled like undriven pins.
REQ-021 SHALL, while capturing, run a rate counter loaded with SAMPLE_RATE at capture start and after each sample, decrementing each cycle.
REQ-022 SHALL take a sample when the counter is <=1; SAMPLE_RATE 0 or 1 SHALL therefore sample every cycle.
REQ-023 SHALL build each sample word as {sample_cnt[15:0], 16-bit zero-extended (synchronized pins AND CAPTURE_MASK)}.
REQ-024 SHALL increment sample_cnt (16b, wraps FFFF->0000) once per sample taken, including dropped samples; start capture SHALL clear it to 0.
REQ-025 SHALL push each sample into the FIFO; if the FIFO is full and no pop occurs that cycle, it SHALL drop the sample and set overflow.
REQ-026 SHALL accept a push and a pop in the same cycle when full, without setting overflow.
REQ-027 SHALL drive sample_valid=1 whenever the FIFO is non-empty, with sample_data = head entry, and pop on sample_valid&sample_ready.
REQ-028 SHALL drive sample_data=0 when sample_valid=0.
REQ-029 SHALL keep FIFO contents after stop capture; flush SHALL empty the FIFO in one cycle, and a pop or push that cycle is discarded.
REQ-030 SHALL treat start capture while already capturing as a restart: clear sample_cnt, reload the rate counter, keep the FIFO.

Reset
REQ-031 SHALL, on reset, set all MODE=idle (pins Z), accumulators, NCO, SAMPLE_RATE, CAPTURE_MASK and sample_cnt to 0, capturing=0, FIFO empty, overflow=0, data_out=0, sample_valid=0.
REQ-032 SHALL make reset dominate simultaneous bus writes, pushes and pops; reset mid-capture SHALL lose all buffered samples.

Verification
REQ-033 SHALL cover: pin1 MODE=nco, NCO=0x40000000 -> pin[1] period 4 cycles, 50% duty; write MODE=high -> pin[1]=1 next cycle.
REQ-034 SHALL cover: SAMPLE_RATE=4, mask=0xF, pins=0xA, start -> one sample every 4 cycles, words 0x0000000A, 0x0001000A, ...
REQ-035 SHALL cover: sample_ready=0, rate 1, FIFO_DEPTH=16 -> fill reaches 16, overflow=1; next sample_cnt skips dropped counts; CTRL=3 -> fill 0, overflow 0.
REQ-036 SHALL cover: FIFO full with sample_ready=1 every cycle -> no overflow, fill stays 16, consecutive sample_cnt values.
REQ-037 SHALL cover: read STATUS/pin page NPINS+1/POSITION mismatch -> data_out valid after 1 cycle, 0 for unmapped and non-selected accesses.
REQ-038 SHALL cover: reset asserted mid-capture with FIFO holding 5 entries -> next cycle sample_valid=0, all pins Z, STATUS=0.
